// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Request ids, the in-flight tag record, mask width and maximum read latency.
package mem_arb_pkg;

    localparam int MASK_W          = 4;
    localparam int MAX_MEM_LATENCY = 4;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } arb_tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of read tags; the head is the tag whose data
// is on the memory read bus this cycle. Ports: clk, rst_n (sync, active-low), push, head.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  arb_tag_t push,
    output arb_tag_t head
);

    arb_tag_t q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            q[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign head = q[DEPTH-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported unified memory
// and routes returning read data back to the port that issued the read.
// Ports: i_clk, i_rst_n (sync, active-low); fetch i_if_req/i_if_addr ->
// o_if_gnt/o_if_rvalid/o_if_rdata; data i_d_req/i_d_wen/i_d_addr/i_d_wdata/
// i_d_mask -> o_d_gnt/o_d_rvalid/o_d_rdata; memory o_mem_addr/o_mem_ren/
// o_mem_wen/o_mem_wdata/o_mem_mask, i_mem_rdata; o_conflict_cnt (saturating).
// Build option: UNIFIED_MEM_ARB_RR_EN selects round-robin on conflict,
// otherwise the data port always wins a conflict.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_wen,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    input  logic [MASK_W-1:0] i_d_mask,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [31:0]       o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_mask,
    input  logic [31:0]       i_mem_rdata,
    output logic [15:0]       o_conflict_cnt
);

    // Legal latency is 1..MAX_MEM_LATENCY; clamp so a bad value still elaborates.
    localparam int TAG_DEPTH =
        (MEM_LATENCY < 1) ? 1 :
        (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;

    logic     run;
    logic     conflict;
    logic     d_wins;
    arb_tag_t push_tag;
    arb_tag_t head_tag;

    // No grants while reset is held, so every output reads 0 in reset.
    assign run      = i_rst_n;
    assign conflict = i_if_req & i_d_req;

`ifdef UNIFIED_MEM_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr=1 favours data; it only moves on a conflict.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr <= 1'b1;
        end else if (conflict) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign d_wins = rr_ptr;
`else
    assign d_wins = 1'b1;
`endif

    always_comb begin
        o_if_gnt = 1'b0;
        o_d_gnt  = 1'b0;
        unique case (1'b1)
            run & conflict: begin
                o_d_gnt  = d_wins;
                o_if_gnt = ~d_wins;
            end
            run & i_d_req & ~i_if_req: o_d_gnt  = 1'b1;
            run & i_if_req & ~i_d_req: o_if_gnt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        unique case (1'b1)
            o_d_gnt: begin
                o_mem_addr  = i_d_addr;
                o_mem_ren   = ~i_d_wen;
                o_mem_wen   = i_d_wen;
                o_mem_wdata = i_d_wdata;
                o_mem_mask  = i_d_mask;
            end
            o_if_gnt: begin
                o_mem_addr = i_if_addr;
                o_mem_ren  = 1'b1;
                o_mem_mask = '1;
            end
            default: ;
        endcase
    end

    // Only reads occupy a tag slot; writes and idle cycles push a bubble.
    always_comb begin
        push_tag       = '0;
        push_tag.valid = o_mem_ren;
        push_tag.id    = o_d_gnt ? REQ_D : REQ_IF;
    end

    arb_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_tag),
        .head  (head_tag)
    );

    assign o_if_rvalid = run & head_tag.valid & (head_tag.id == REQ_IF);
    assign o_d_rvalid  = run & head_tag.valid & (head_tag.id == REQ_D);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
    assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : 32'h0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_conflict_cnt <= '0;
        end else if (conflict && (o_conflict_cnt != 16'hFFFF)) begin
            o_conflict_cnt <= o_conflict_cnt + 16'd1;
        end
    end

endmodule
